hs_sample_capture: RTL and testbench

//  Capture core behind the hi_speed_sampler AXI4-Lite register file. Samples a parallel

---
 rtl/hs_sample_capture.sv | 190 +++++++++++++++++++
 tb/tb_hs_sample_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sample_capture.sv
// Capture core: decimated sampling of din into a circular buffer with pre-trigger
// history, mask/value trigger and a programmed number of post-trigger samples.
module hs_sample_capture #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int DECIM_W    = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_W-1:0]     din,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     trig_mask,
    input  logic [DATA_W-1:0]     trig_value,
    input  logic [DEPTH_LOG2-1:0] post_count,
    input  logic [DECIM_W-1:0]    decim,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_addr,
    output logic [DEPTH_LOG2-1:0] start_addr,
    output logic [2:0]            dbg_state
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] count_q, count_d;
    logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
    logic [DEPTH_LOG2-1:0] start_addr_q, start_addr_d;
    logic [DEPTH_LOG2-1:0] post_q, post_d;
    logic [DEPTH_LOG2-1:0] pre_q, pre_d;
    logic [DECIM_W-1:0]    decim_q, decim_d;
    logic [DECIM_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]     mask_q, mask_d;
    logic [DATA_W-1:0]     value_q, value_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  busy_w;
    logic                  arm_ok;
    logic                  strobe;
    logic                  hit;
    logic                  we;
    logic [DEPTH_LOG2-1:0] pre_arm;

    assign busy_w  = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign arm_ok  = arm && !abort && !busy_w;
    assign strobe  = (cnt_q == '0);
    assign hit     = (((din ^ value_q) & mask_q) == '0);
    assign pre_arm = {DEPTH_LOG2{1'b1}} - post_count;

    // Decimation counter restarts on arm so the first sample lands the cycle after arm.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (arm_ok || (cnt_q == decim_q)) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        post_d       = post_q;
        pre_d        = pre_q;
        decim_d      = decim_q;
        mask_d       = mask_q;
        value_d      = value_q;
        we           = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        post_d   = post_count;
                        pre_d    = pre_arm;
                        decim_d  = decim;
                        mask_d   = trig_mask;
                        value_d  = trig_value;
                        wr_ptr_d = '0;
                        count_d  = '0;
                        state_d  = (pre_arm == '0) ? S_WAIT_TRIG : S_PRE;
                    end
                end
                S_PRE: begin
                    if (strobe) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                        if (count_q == pre_q - 1'b1) begin
                            state_d = S_WAIT_TRIG;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (strobe) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (hit) begin
                            trig_addr_d = wr_ptr_q;
                            count_d     = '0;
                            if (post_q == '0) begin
                                // trig_addr - pre equals trig_addr + 1 when nothing follows
                                start_addr_d = wr_ptr_q + 1'b1;
                                state_d      = S_DONE;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (strobe) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                        if (count_q == post_q - 1'b1) begin
                            start_addr_d = wr_ptr_q + 1'b1;
                            state_d      = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            post_q       <= '0;
            pre_q        <= '0;
            decim_q      <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            post_q       <= post_d;
            pre_q        <= pre_d;
            decim_q      <= decim_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Buffer has no reset; read-first behaviour falls out of the registered read.
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign busy       = busy_w;
    assign done       = (state_q == S_DONE);
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hs_sample_capture.sv
// Bench for hs_sample_capture: directed capture scenarios plus randomized captures
// compared against a sample-list model of the buffer.
module tb_hs_sample_capture;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 4;
  localparam int DECIM_W    = 16;
  localparam int DEPTH      = 16;
  localparam int MAXT       = 1024;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic [DATA_W-1:0]     din = '0;
  logic                  arm = 1'b0;
  logic                  abort = 1'b0;
  logic [DATA_W-1:0]     trig_mask = '0;
  logic [DATA_W-1:0]     trig_value = '0;
  logic [DEPTH_LOG2-1:0] post_count = '0;
  logic [DECIM_W-1:0]    decim = '0;
  logic [DEPTH_LOG2-1:0] rd_addr = '0;
  logic [DATA_W-1:0]     rd_data;
  logic                  busy;
  logic                  done;
  logic [DEPTH_LOG2-1:0] trig_addr;
  logic [DEPTH_LOG2-1:0] start_addr;
  logic [2:0]            dbg_state;

  hs_sample_capture #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .DECIM_W(DECIM_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .din(din), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
    .decim(decim), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] din_arr [MAXT];
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic fill_count();
    for (int i = 0; i < MAXT; i++) din_arr[i] = i;
  endtask

  // Sample i is din at cycle i*(decim+1); first hit at index >= pre is the trigger.
  task automatic model(input logic [31:0] mask, input logic [31:0] value, input int post,
                       input int dec, output int j, output int n);
    int pre;
    pre = DEPTH - 1 - post;
    j = -1;
    for (int i = pre; i * (dec + 1) < MAXT; i++) begin
      if (((din_arr[i * (dec + 1)] ^ value) & mask) == 0) begin
        j = i;
        break;
      end
    end
    n = j + post + 1;
  endtask

  task automatic do_arm(input logic [31:0] mask, input logic [31:0] value, input int post,
                        input int dec);
    trig_mask  = mask;
    trig_value = value;
    post_count = DEPTH_LOG2'(post);
    decim      = DECIM_W'(dec);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    // later config changes must not affect the running capture
    trig_mask  = $urandom;
    trig_value = $urandom;
    post_count = DEPTH_LOG2'($urandom_range(0, 15));
    decim      = DECIM_W'($urandom_range(0, 7));
  endtask

  task automatic drive_cycles(input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      din = din_arr[t];
      tick();
    end
  endtask

  task automatic run_capture(input string tag, input logic [31:0] mask, input logic [31:0] value,
                             input int post, input int dec, input int arm_at);
    int j, n, t_done;
    logic busy_ok;
    logic [DATA_W-1:0] em [DEPTH];
    model(mask, value, post, dec, j, n);
    for (int a = 0; a < DEPTH; a++) em[a] = '0;
    for (int i = 0; i < n; i++) em[i % DEPTH] = din_arr[i * (dec + 1)];
    do_arm(mask, value, post, dec);
    check({tag, "_busy_after_arm"}, 32'(busy), 32'd1);
    t_done = -1;
    busy_ok = 1'b1;
    for (int t = 0; t < MAXT && t_done < 0; t++) begin
      din = din_arr[t];
      arm = (t == arm_at);
      tick();
      if (done) t_done = t;
      else if (!busy) busy_ok = 1'b0;
    end
    arm = 1'b0;
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_done_cycle"}, 32'(t_done), 32'((n - 1) * (dec + 1)));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_trig_addr"}, 32'(trig_addr), 32'(j % DEPTH));
    check({tag, "_start_addr"}, 32'(start_addr), 32'(n % DEPTH));
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(em[a]);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = DEPTH_LOG2'(a);
      tick();
      check({tag, "_rd"}, rd_data, exp_q.pop_front());
    end
  endtask

  task automatic read_check(input string tag, input int a, input logic [31:0] exp);
    rd_addr = DEPTH_LOG2'(a);
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    int pre, k, dec, post;
    logic [31:0] mask, value;

    // 1 reset
    ARESETN = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_start_addr", 32'(start_addr), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    ARESETN = 1'b1;
    tick();

    // 2 basic capture
    fill_count();
    run_capture("basic", 32'hFFFF_FFFF, 32'h20, 4, 0, -1);
    check("basic_trig_const", 32'(trig_addr), 32'd0);
    check("basic_start_const", 32'(start_addr), 32'd5);
    read_check("basic_rd5", 5, 32'h15);
    read_check("basic_rd0", 0, 32'h20);
    read_check("basic_rd4", 4, 32'h24);

    // 3 decimation
    run_capture("decim", 32'hFFFF_FFFF, 32'h40, 4, 3, -1);
    read_check("decim_rd0", 0, 32'h40);
    read_check("decim_rd15", 15, 32'h3C);

    // 4 zero pre-trigger
    run_capture("nopre", 32'h0, 32'h1234, 15, 0, -1);
    check("nopre_trig_const", 32'(trig_addr), 32'd0);
    check("nopre_start_const", 32'(start_addr), 32'd0);
    read_check("nopre_rd9", 9, 32'h09);

    // 5 abort during POST, trigger at sample 0x23 -> addr 3
    do_arm(32'hFFFF_FFFF, 32'h23, 4, 0);
    drive_cycles(37);
    check("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_trig_kept", 32'(trig_addr), 32'd3);
    run_capture("rearm", 32'hFFFF_FFFF, 32'h20, 4, 0, -1);

    // reset pulse mid-PRE
    do_arm(32'hFFFF_FFFF, 32'h20, 4, 0);
    drive_cycles(5);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_start_addr", 32'(start_addr), 32'd0);
    #2 ARESETN = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);

    // 6 arm while busy ignored; post=0 trigger on 0x11
    run_capture("rearm_busy", 32'hFFFF_FFFF, 32'h11, 0, 0, 3);
    check("post0_trig_const", 32'(trig_addr), 32'd1);
    check("post0_start_const", 32'(start_addr), 32'd2);

    // arm+abort together from DONE and from busy
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("armabort_done_busy", 32'(busy), 32'd0);
    check("armabort_done_done", 32'(done), 32'd0);
    do_arm(32'hFFFF_FFFF, 32'h20, 4, 0);
    drive_cycles(3);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("armabort_busy_busy", 32'(busy), 32'd0);
    tick();
    check("armabort_busy_stay", 32'(busy), 32'd0);

    // randomized captures
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MAXT; i++) din_arr[i] = $urandom;
      dec  = $urandom_range(0, 3);
      post = $urandom_range(0, 15);
      pre  = DEPTH - 1 - post;
      k    = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0:       mask = 32'hFFFF_FFFF;
        1:       mask = $urandom & 32'h0000_00FF;
        default: mask = $urandom;
      endcase
      value = din_arr[(pre + k) * (dec + 1)] ^ (~mask & $urandom);
      run_capture("rand", mask, value, post, dec, ($urandom_range(0, 1) == 1) ? 2 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
